ma_result_buffer: RTL and testbench
===================================

// Module: ma_result_buffer
// PURPOSE
//  Downstream stage of the moving-average filter: captures each filtered sample (dout qualified by
//  output_pulse) into a small FIFO and hands it to the consumer over a valid/ready stream.
//  Also tracks running min/max of accepted samples and counts samples dropped on overflow.
//  Decouples the filter's one-cycle output pulse from a consumer that may stall.
// PARAMETERS
//  DW     16  sample width, signed two's complement; must match the filter output width.
//  DEPTH  8   FIFO entries; power of two, >= 2.
//  CNT_W  8   width of the saturating drop counter.
// PORTS
//  clk          in   1         clock; all logic is on its rising edge.
//  rst_n        in   1         synchronous reset, active low.
//  enable       in   1         1 = accept input samples; 0 = ignore in_valid (reads continue).
//  clear        in   1         sync flush: empties the FIFO, resets stats/flags; not a full reset.
//  in_data      in   DW        signed sample, driven from the filter's dout.
//  in_valid     in   1         one-cycle write strobe, driven from the filter's output_pulse.
//  out_ready    in   1         consumer ready.
//  out_data     out  DW        signed head-of-FIFO sample (first-word fall-through).
//  out_valid    out  1         FIFO non-empty.
//  level        out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
//  overflow     out  1         sticky; set on the first dropped sample.
//  drop_cnt     out  CNT_W     dropped-sample count, saturating at all-ones.
//  stat_valid   out  1         1 once at least one sample has been accepted since reset/clear.
//  stat_min     out  DW        signed minimum of accepted samples.
//  stat_max     out  DW        signed maximum of accepted samples.
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): pointers, level, out_valid, overflow, drop_cnt, stat_valid = 0;
//    stat_min = 0, stat_max = 0, out_data = 0. Memory contents need not be reset.
//  - push = enable & in_valid; pop = out_valid & out_ready (one transfer per edge).
//  - Latency: sample pushed at edge T into an empty FIFO gives out_valid=1, out_data=sample after T.
//  - out_data is stable while out_valid=1 and out_ready=0.
//  - Full, push, no pop: sample dropped, FIFO unchanged, overflow<=1, drop_cnt+1 (sat).
//  - Full, push and pop in the same cycle: both succeed, level stays DEPTH, no drop.
//  - Empty, pop attempted: impossible (out_valid=0); out_ready alone has no effect.
//  - Pointers wrap modulo DEPTH; level computed from a separate counter, not pointer difference.
//  - Stats update only on accepted (non-dropped) pushes. First accepted sample after reset/clear
//    loads both min and max and sets stat_valid. Later pushes use signed compare:
//    min<=in if in<min, max<=in if in>max. Stats are not affected by pops.
//  - clear=1: same effect as reset on every register except memory; it takes priority over
//    push and pop in the same cycle, and the sample offered in that cycle is discarded.
//  - rst_n has priority over clear; reset during a burst discards all buffered data.
//  - enable=0 blocks writes only; the consumer can still drain the FIFO.
//  - No arithmetic on sample values except compare; no truncation, and widths are preserved.
// STRUCTURE
//  - Shared package ma_pkg: DW constant (16), sample typedef (signed [DW-1:0]), and the
//    averaging-mode encodings (000 none, 001 2pt, 010 3pt, 011 4pt, 100 8pt, 101 16pt) used by the filter and its bench.
//  - One sub-module: ma_fifo_core (memory, wrapping pointers, level counter, full/empty).
//    Top level holds the push/pop qualification, drop/overflow logic and min/max tracker.
// TESTING
//  1 Reset: hold rst_n=0 for 3 clk -> all outputs 0. Push 16'sh0123 -> next cycle out_valid=1,
//    out_data=16'sh0123, level=1.
//  2 Fill/drain: push -1,-2..-8 with out_ready=0 -> level=8, no overflow. Then out_ready=1 ->
//    -1..-8 come out in order over 8 cycles, then out_valid=0, level=0.
//  3 Overflow: with full FIFO, push 3 more -> drop_cnt=3, overflow=1, contents unchanged.
//    With CNT_W=2 and 5 drops -> drop_cnt=3 (saturated).
//  4 Full push+pop: full FIFO, push 16'sh7FFF with out_ready=1 -> no drop, level=8,
//    16'sh7FFF is last out.
//  5 Stats: push 5, -32768, 32767, 0 -> stat_min=-32768, stat_max=32767, stat_valid=1.
//    Then clear -> stat_valid=0, level=0; the sample offered with clear is not stored.
//  6 enable=0: in_valid pulses are ignored (level unchanged) while a pending sample still drains.

Source files
------------

// File: rtl/ma_pkg.sv
// Shared definitions for the moving-average filter and its downstream result buffer.
package ma_pkg;

  localparam int DW = 16;

  typedef logic signed [DW-1:0] sample_t;

  typedef enum logic [2:0] {
    AVG_NONE = 3'b000,
    AVG_2PT  = 3'b001,
    AVG_3PT  = 3'b010,
    AVG_4PT  = 3'b011,
    AVG_8PT  = 3'b100,
    AVG_16PT = 3'b101
  } avg_mode_e;

endpackage

// File: rtl/ma_fifo_core.sv
// First-word fall-through FIFO storage: wrapping pointers, occupancy counter, full/empty.
module ma_fifo_core
  import ma_pkg::*;
#(
  parameter int DW    = ma_pkg::DW,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_ff @(posedge clk) begin
    if (rst_n && !flush && wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ma_result_buffer.sv
// Captures filter output pulses into a FIFO, streams them out valid/ready,
// and tracks min/max of accepted samples plus a saturating drop count.
module ma_result_buffer
  import ma_pkg::*;
#(
  parameter int DW    = ma_pkg::DW,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic signed [DW-1:0]     in_data,
  input  logic                     in_valid,
  input  logic                     out_ready,
  output logic signed [DW-1:0]     out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     stat_valid,
  output logic signed [DW-1:0]     stat_min,
  output logic signed [DW-1:0]     stat_max
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          push, pop, accept, drop;
  logic          full, empty;
  logic [DW-1:0] head;

  assign push   = enable & in_valid;
  assign pop    = out_valid & out_ready;
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  ma_fifo_core #(.DW(DW), .DEPTH(DEPTH), .LW(LW)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clear),
    .wr_en   (accept),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // Memory is never reset, so hide its contents while nothing is buffered.
  assign out_valid = ~empty;
  assign out_data  = out_valid ? $signed(head) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      stat_valid <= 1'b0;
      stat_min   <= '0;
      stat_max   <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
      if (accept) begin
        stat_valid <= 1'b1;
        if (!stat_valid || in_data < stat_min) stat_min <= in_data;
        if (!stat_valid || in_data > stat_max) stat_max <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_ma_result_buffer.sv
// Bench for ma_result_buffer: constant vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_ma_result_buffer;

  localparam int DW = 16;
  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst_n, enable, clear, in_valid, out_ready;
  logic signed [DW-1:0] in_data;
  logic signed [DW-1:0] out_data, out_data2, stat_min, stat_max, stat_min2, stat_max2;
  logic                out_valid, out_valid2, overflow, overflow2, stat_valid, stat_valid2;
  logic [3:0]          level, level2;
  logic [7:0]          drop_cnt;
  logic [1:0]          drop_cnt2;

  always #5 clk = ~clk;

  ma_result_buffer #(.DW(DW), .DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt), .stat_valid(stat_valid),
    .stat_min(stat_min), .stat_max(stat_max)
  );

  // Narrow drop counter instance to exercise saturation; same stimulus.
  ma_result_buffer #(.DW(DW), .DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .out_ready(out_ready),
    .out_data(out_data2), .out_valid(out_valid2), .level(level2),
    .overflow(overflow2), .drop_cnt(drop_cnt2), .stat_valid(stat_valid2),
    .stat_min(stat_min2), .stat_max(stat_max2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int q[$];
  int m_drops;
  bit m_ovf, m_sv;
  int m_min, m_max;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_drops = 0; m_ovf = 0; m_sv = 0; m_min = 0; m_max = 0;
  endtask

  task automatic model_edge();
    bit do_pop, do_push, was_full;
    int d;
    if (!rst_n || clear) begin
      model_clear();
    end else begin
      d        = int'(in_data);
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() > 0) && out_ready;
      do_push  = enable && in_valid;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        if (!was_full || do_pop) begin
          q.push_back(d);
          if (!m_sv) begin m_min = d; m_max = d; end
          else begin
            if (d < m_min) m_min = d;
            if (d > m_max) m_max = d;
          end
          m_sv = 1;
        end else begin
          m_drops++;
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic check_model();
    int exp_data;
    exp_data = (q.size() > 0) ? q[0] : 0;
    check("out_valid", int'(out_valid), int'(q.size() > 0));
    check("out_data", int'(out_data), exp_data);
    check("level", int'(level), q.size());
    check("overflow", int'(overflow), int'(m_ovf));
    check("drop_cnt", int'(drop_cnt), (m_drops > 255) ? 255 : m_drops);
    check("drop_cnt_w2", int'(drop_cnt2), (m_drops > 3) ? 3 : m_drops);
    check("stat_valid", int'(stat_valid), int'(m_sv));
    check("stat_min", int'(stat_min), m_min);
    check("stat_max", int'(stat_max), m_max);
    check("w2_level", int'(level2), q.size());
  endtask

  // Drive at negedge, let the DUT take the edge, then compare at the next negedge.
  task automatic step(input bit en, input bit clr, input bit vld, input bit rdy, input int d);
    enable    = en;
    clear     = clr;
    in_valid  = vld;
    out_ready = rdy;
    in_data   = DW'(d);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  typedef struct {
    bit              en, clr, vld, rdy;
    logic [DW-1:0]   data;
    int              exp_level;
    bit              exp_valid;
    logic [DW-1:0]   exp_data;
    bit              exp_sv;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{1, 0, 1, 0, 16'h0123, 1, 1, 16'h0123, 1};
    vt[1] = '{1, 0, 1, 0, 16'hFFFF, 2, 1, 16'h0123, 1};
    vt[2] = '{0, 0, 1, 0, 16'h0005, 2, 1, 16'h0123, 1};
    vt[3] = '{1, 0, 0, 1, 16'h0007, 1, 1, 16'hFFFF, 1};
    vt[4] = '{1, 0, 1, 1, 16'h8000, 1, 1, 16'h8000, 1};
    vt[5] = '{0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 1};
    vt[6] = '{0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 1};
    vt[7] = '{1, 1, 1, 0, 16'h1234, 0, 0, 16'h0000, 0};
    vt[8] = '{1, 0, 1, 0, 16'h7FFF, 1, 1, 16'h7FFF, 1};

    rst_n = 1'b0; enable = 0; clear = 0; in_valid = 0; out_ready = 0; in_data = '0;
    model_clear();
    @(negedge clk);

    // Reset held for three clocks: every output reads zero.
    for (int i = 0; i < 3; i++) idle();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    check("rst_stats", int'({overflow, stat_valid, stat_min, stat_max}), 0);
    rst_n = 1'b1;
    idle();

    // Constant vector table.
    for (int i = 0; i < 9; i++) begin
      step(vt[i].en, vt[i].clr, vt[i].vld, vt[i].rdy, int'($signed(vt[i].data)));
      check($sformatf("vec%0d_level", i), int'(level), vt[i].exp_level);
      check($sformatf("vec%0d_valid", i), int'(out_valid), int'(vt[i].exp_valid));
      check($sformatf("vec%0d_data", i), int'(out_data), int'($signed(vt[i].exp_data)));
      check($sformatf("vec%0d_sv", i), int'(stat_valid), int'(vt[i].exp_sv));
    end

    // Fill with -1..-8, overflow by 5, check saturation and that contents survived.
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(1, 0, 1, 0, -i);
    check("fill_level", int'(level), 8);
    check("fill_no_ovf", int'(overflow), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 100 + i);
    check("ovf_drop3", int'(drop_cnt), 3);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_level", int'(level), 8);
    for (int i = 0; i < 2; i++) step(1, 0, 1, 0, 200 + i);
    check("ovf_drop5", int'(drop_cnt), 5);
    check("ovf_sat_w2", int'(drop_cnt2), 3);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", int'(out_data), -i);
      step(0, 0, 0, 1, 0);
    end
    check("drain_empty", int'(out_valid), 0);
    check("drain_level", int'(level), 0);

    // Full FIFO, simultaneous push and pop: nothing dropped, new sample lands last.
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(1, 0, 1, 0, i);
    step(1, 0, 1, 1, 32767);
    check("fpp_level", int'(level), 8);
    check("fpp_nodrop", int'(drop_cnt), 0);
    for (int i = 0; i < 8; i++) begin
      check("fpp_order", int'(out_data), (i == 7) ? 32767 : i + 2);
      step(0, 0, 0, 1, 0);
    end

    // Signed extremes in the stats, then clear discards its own sample.
    step(0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 5);
    step(1, 0, 1, 1, -32768);
    step(1, 0, 1, 1, 32767);
    step(1, 0, 1, 1, 0);
    check("stat_min", int'(stat_min), -32768);
    check("stat_max", int'(stat_max), 32767);
    check("stat_valid", int'(stat_valid), 1);
    step(1, 0, 1, 0, 9);
    step(1, 1, 1, 0, 99);
    check("clr_sv", int'(stat_valid), 0);
    check("clr_level", int'(level), 0);
    idle();
    check("clr_discard", int'(out_valid), 0);

    // enable=0 ignores writes while the pending sample still drains.
    step(1, 0, 1, 0, 42);
    step(0, 0, 1, 0, 43);
    step(0, 0, 1, 0, 44);
    check("en0_level", int'(level), 1);
    step(0, 0, 1, 1, 45);
    check("en0_drained", int'(level), 0);

    // Random traffic with occasional reset/clear; ready bias shifts between phases.
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 300) % 3 == 0) ? 15 : ((i / 300) % 3 == 1) ? 50 : 90;
      rst_n = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < rdy_pct,
           int'($signed(16'($urandom))));
    end
    rst_n = 1'b1;

    // Reset in the middle of a burst drops everything buffered.
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, i);
    rst_n = 1'b0;
    step(1, 0, 1, 0, 77);
    rst_n = 1'b1;
    check("burst_rst_level", int'(level), 0);
    check("burst_rst_data", int'(out_data), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
